// File: rtl/barrel_shifter_8bit.sv
// Registered 8-bit logical right barrel shifter: out <= in >> ctrl, zero fill.
// Three log-shift mux stages (1, 2, 4) feed a single output register.

module barrel_shifter_8bit_stage #(
    parameter int SHIFT = 1
) (
    input  logic [7:0] din,
    input  logic       sel,
    output logic [7:0] dout
);
    always_comb begin
        dout = din;
        if (sel) dout = din >> SHIFT;
    end
endmodule

module barrel_shifter_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic [2:0] ctrl,
    output logic [7:0] out
);
    // stg[g] is the input of stage g; stg[3] is the fully shifted word
    logic [3:0][7:0] stg;
    logic [7:0]      out_d;
    logic [7:0]      out_q;

    assign stg[0] = in;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_stage
            barrel_shifter_8bit_stage #(.SHIFT(1 << g)) u_stage (
                .din  (stg[g]),
                .sel  (ctrl[g]),
                .dout (stg[g+1])
            );
        end
    endgenerate

    always_comb begin
        out_d = stg[3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= 8'h00;
        else     out_q <= out_d;
    end

    assign out = out_q;
endmodule

// File: tb/tb_barrel_shifter_8bit.sv
// Scoreboard bench for barrel_shifter_8bit: driver queues hand-computed
// results, monitor pops one per clock edge and compares against out.

module tb_barrel_shifter_8bit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_r = 8'hFF;
    logic [2:0] ctrl_r = 3'd0;
    logic [7:0] out_w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    barrel_shifter_8bit dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in_r),
        .ctrl (ctrl_r),
        .out  (out_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge; the result is due one rising edge later.
    task automatic apply(input logic r, input logic [7:0] d, input logic [2:0] c,
                         input logic [7:0] exp, input string name);
        @(negedge clk);
        rst    = r;
        in_r   = d;
        ctrl_r = c;
        exp_q.push_back(exp);
        tag_q.push_back(name);
    endtask

    // Monitor: one result per rising edge while the scoreboard has entries
    initial begin
        logic [7:0] e;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, out_w, e);
            end
        end
    end

    initial begin
        logic [7:0] b6_exp [8];
        b6_exp = '{8'hB6, 8'h5B, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01};

        #1;
        check("reset_async_t0", out_w, 8'h00);

        apply(1'b1, 8'hFF, 3'd0, 8'h00, "reset_hold0");
        apply(1'b1, 8'hFF, 3'd0, 8'h00, "reset_hold1");
        apply(1'b1, 8'hFF, 3'd0, 8'h00, "reset_hold2");
        apply(1'b0, 8'hFF, 3'd0, 8'hFF, "reset_release");

        apply(1'b0, 8'h00, 3'd0, 8'h00, "pass_zero");
        apply(1'b0, 8'hA5, 3'd0, 8'hA5, "pass_a5");

        apply(1'b0, 8'h80, 3'd4, 8'h08, "msb_shr4");
        apply(1'b0, 8'h80, 3'd2, 8'h20, "msb_shr2");
        apply(1'b0, 8'h80, 3'd1, 8'h40, "msb_shr1");

        apply(1'b0, 8'hFF, 3'd7, 8'h01, "ff_shr7");
        apply(1'b0, 8'hFF, 3'd3, 8'h1F, "ff_shr3");

        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 8'hB6, 3'(k), b6_exp[k], $sformatf("b6_shr%0d", k));
            if (k == 3) begin
                // Async pulse between edges: out (0x2D) must clear with no clock,
                // and the next edge must load the current in >> ctrl (0x16).
                #2 rst = 1'b1;
                #1 check("midreset_async", out_w, 8'h00);
                #1 rst = 1'b0;
                #0.5 check("midreset_hold", out_w, 8'h00);
            end
        end

        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard bound on run length
    initial begin
        #5000;
        n_bad++;
        $display("FAIL timeout: simulation reached %0t, expected finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
